sram_photo_streamer: RTL and testbench
======================================

// Module: sram_photo_streamer
// PURPOSE
//  Reads a stored photo back out of the 16-bit SRAM in the packed frame-capture format
//  (2 words/pixel: word0={R[7:0],G[7:0]}, word1={B[7:0],8'h00}) and streams it in raster order.
//  Output is 30-bit RGB with a valid/ready handshake, for downstream filter/blend/compare logic.
//  Read-only SRAM master. It owns the SRAM bus only while oBusy=1.
// PARAMETERS
//  ADDR_W  20  SRAM word-address width
//  IDX_W   4   photo index width
// PORTS
//  iCLK         in   1       clock
//  iRST_N       in   1       asynchronous reset, active low
//  iStart       in   1       1-cycle pulse: begin streaming photo iPhoto_Index (ignored while oBusy)
//  iAbort       in   1       stop immediately and return to IDLE
//  iPhoto_Index in   IDX_W   photo slot; latched on accepted iStart
//  iCol_MAX     in   10      photo width in pixels; latched on iStart
//  iRow_MAX     in   10      photo height in pixels; latched on iStart
//  iSRAM_In     in   16      SRAM read data
//  oSRAM_Addr   out  ADDR_W  SRAM word address (registered)
//  oSRAM_CE_N/UB_N/LB_N out 1 tied 0
//  oSRAM_WE_N   out  1       tied 1 (never writes)
//  oSRAM_OE_N   out  1       0 while oBusy, else 1
//  oRGB         out  30      {R,2'b00,G,2'b00,B,2'b00}
//  oValid       out  1       oRGB/markers valid
//  iReady       in   1       consumer accepts when oValid&iReady at posedge
//  oSOF/oEOL/oEOF out 1      first pixel / last pixel of row / last pixel of frame, qualified by oValid
//  oBusy        out  1       1 from accepted iStart until oDone
//  oDone        out  1       1-cycle pulse at end of frame
// BEHAVIOUR
//  Reset: state IDLE, oSRAM_Addr=0, oRGB=0, oValid=oSOF=oEOL=oEOF=oBusy=oDone=0, OE_N=1.
//  SRAM timing: oSRAM_Addr is held stable for one full cycle. iSRAM_In is sampled on the posedge ending that cycle.
//  Base address = iPhoto_Index*iCol_MAX*iRow_MAX*2 is computed at iStart and truncated to ADDR_W.
//  Pixel (c,r) word0 = base+2*(r*iCol_MAX+c); word1 = word0+1.
//  FSM:
//   IDLE -> RD_HI on iStart with nonzero dims. Address=base, col=row=0.
//   IDLE on iStart with iCol_MAX==0 or iRow_MAX==0: oDone pulse next cycle, no pixels, stay IDLE.
//   RD_HI: latch iSRAM_In[15:8]=R and [7:0]=G, address+1 -> RD_LO.
//   RD_LO: the output slot is free if oValid==0, or oValid&iReady in this cycle.
//     Slot free: load oRGB with B=iSRAM_In[15:8] and set oValid=1 with SOF/EOL/EOF from col/row.
//     Slot free: address+1, advance col/row. Last pixel -> DRAIN, else -> RD_HI.
//     Slot not free: stall in RD_LO with the address held. The load happens on the first free cycle.
//   DRAIN: wait for oValid&iReady -> oValid=0, oDone=1 for 1 cycle, oBusy=0 -> IDLE.
//  Throughput: 1 pixel / 2 cycles with iReady held high. First oValid appears 2 cycles after the iStart edge.
//  oValid, once set, is held with oRGB stable until accepted. Dropping oValid without acceptance happens only on abort/reset.
//  Counters: col wraps to 0 at iCol_MAX-1 with row+1. EOL=(col==iCol_MAX-1). EOF=EOL&(row==iRow_MAX-1).
//  iAbort: highest priority in any state. Next cycle: IDLE, oValid=0, oBusy=0, OE_N=1, no oDone.
//  iAbort together with iStart in IDLE: the abort wins and nothing starts.
//  iStart while oBusy: ignored, and the latched dims/index are unaffected.
//  Async reset mid-frame: all outputs go to reset values immediately, with no partial oDone.
// TESTING
//  1. Idx=0, 2x2 image preloaded (pixel k: R=k,G=k+16,B=k+32), iReady=1.
//     -> 4 pixels, oRGB[29:22]=0..3, SOF on k=0, EOL on k=1,3, EOF on k=3.
//     -> Addresses 0..7. oDone 1 cycle after the last acceptance.
//  2. Idx=3, 4x3 -> first address=72, last address=95. Exactly 12 beats and one oDone.
//  3. Backpressure: iReady=0 for 5 cycles on pixel 1 -> oRGB/oValid stable and address held.
//     -> No pixel lost or duplicated after iReady returns.
//  4. iAbort on pixel 2 of 4x4 -> next cycle oValid=0, oBusy=0, OE_N=1, no oDone.
//     -> A new iStart then restarts at base with SOF.
//  5. iStart with iCol_MAX=0 -> oDone pulse, no oValid. A second iStart mid-frame is ignored (same beat count).
//  6. iRST_N asserted mid-frame -> all outputs at reset values asynchronously. Stream restarts cleanly after release.

Source files
------------

// File: rtl/sram_photo_streamer.sv
// Streams a stored photo out of the 16-bit SRAM (2 words per pixel) in raster order
// as 30-bit RGB beats with a valid/ready handshake and SOF/EOL/EOF markers.
//
// state | meaning
// IDLE  | bus released, waiting for iStart
// RD_HI | address on word0 of a pixel, capture R/G at the end of the cycle
// RD_LO | address on word1, capture B into the output slot once it is free
// DRAIN | last pixel presented, waiting for it to be accepted
module sram_photo_streamer #(
    parameter int ADDR_W = 20,
    parameter int IDX_W  = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [IDX_W-1:0]  iPhoto_Index,
    input  logic [9:0]        iCol_MAX,
    input  logic [9:0]        iRow_MAX,
    input  logic [15:0]       iSRAM_In,
    output logic [ADDR_W-1:0] oSRAM_Addr,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_UB_N,
    output logic              oSRAM_LB_N,
    output logic              oSRAM_WE_N,
    output logic              oSRAM_OE_N,
    output logic [29:0]       oRGB,
    output logic              oValid,
    input  logic              iReady,
    output logic              oSOF,
    output logic              oEOL,
    output logic              oEOF,
    output logic              oBusy,
    output logic              oDone
);
    localparam int BASE_W = IDX_W + 21;

    typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, DRAIN} state_t;

    state_t state, state_nxt;

    logic [9:0]        col, row, col_max, row_max;
    logic [7:0]        red, green;
    logic [BASE_W-1:0] base_full;
    logic              slot_free, accept, last_col, last_row, zero_dims;
    logic              start_go, zero_done, load_pix, finish;

    assign base_full = BASE_W'(iPhoto_Index) * BASE_W'(iCol_MAX) * BASE_W'(iRow_MAX) * BASE_W'(2);
    assign accept    = oValid & iReady;
    assign slot_free = ~oValid | iReady;
    assign last_col  = (col == col_max - 10'd1);
    assign last_row  = (row == row_max - 10'd1);
    assign zero_dims = (iCol_MAX == 10'd0) | (iRow_MAX == 10'd0);

    assign oSRAM_CE_N = 1'b0;
    assign oSRAM_UB_N = 1'b0;
    assign oSRAM_LB_N = 1'b0;
    assign oSRAM_WE_N = 1'b1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (iAbort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (iStart && !zero_dims) state_nxt = RD_HI;
                RD_HI:   state_nxt = RD_LO;
                RD_LO:   if (slot_free) state_nxt = (last_col && last_row) ? DRAIN : RD_HI;
                DRAIN:   if (accept) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        oBusy      = (state != IDLE);
        oSRAM_OE_N = ~oBusy;
        start_go   = (state == IDLE) & iStart & ~iAbort & ~zero_dims;
        zero_done  = (state == IDLE) & iStart & ~iAbort & zero_dims;
        load_pix   = (state == RD_LO) & slot_free & ~iAbort;
        finish     = (state == DRAIN) & accept & ~iAbort;
    end

    // Abort drops the presented beat without acceptance and suppresses oDone.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oSRAM_Addr <= '0;
            oRGB       <= '0;
            oValid     <= 1'b0;
            oSOF       <= 1'b0;
            oEOL       <= 1'b0;
            oEOF       <= 1'b0;
            oDone      <= 1'b0;
            col        <= '0;
            row        <= '0;
            col_max    <= '0;
            row_max    <= '0;
            red        <= '0;
            green      <= '0;
        end else if (iAbort) begin
            oValid <= 1'b0;
            oSOF   <= 1'b0;
            oEOL   <= 1'b0;
            oEOF   <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            oDone <= finish | zero_done;
            if (start_go) begin
                oSRAM_Addr <= ADDR_W'(base_full);
                col_max    <= iCol_MAX;
                row_max    <= iRow_MAX;
                col        <= '0;
                row        <= '0;
            end
            if (state == RD_HI) begin
                red        <= iSRAM_In[15:8];
                green      <= iSRAM_In[7:0];
                oSRAM_Addr <= oSRAM_Addr + ADDR_W'(1);
            end
            if (load_pix) begin
                oRGB       <= {red, 2'b00, green, 2'b00, iSRAM_In[15:8], 2'b00};
                oValid     <= 1'b1;
                oSOF       <= (col == 10'd0) & (row == 10'd0);
                oEOL       <= last_col;
                oEOF       <= last_col & last_row;
                oSRAM_Addr <= oSRAM_Addr + ADDR_W'(1);
                if (last_col) begin
                    col <= '0;
                    row <= row + 10'd1;
                end else begin
                    col <= col + 10'd1;
                end
            end else if (accept) begin
                oValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sram_photo_streamer.sv
// Bench for sram_photo_streamer: SRAM array model, expected-beat queue built from the
// raster/address rules at each accepted start, and a per-cycle compare process.
module tb_sram_photo_streamer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, abort = 1'b0, ready = 1'b0;
    logic [3:0]  idx = '0;
    logic [9:0]  cmax = '0, rmax = '0;
    logic [15:0] sram_in;
    logic [19:0] sram_addr;
    logic        ce_n, ub_n, lb_n, we_n, oe_n;
    logic [29:0] rgb;
    logic        valid, sof, eol, eof, busy, done;

    int n_cmp = 0, n_err = 0;

    logic [15:0] sram [0:4095];

    always #5 clk = ~clk;

    assign sram_in = (sram_addr[19:12] == 8'd0) ? sram[sram_addr[11:0]] : 16'hDEAD;

    sram_photo_streamer #(.ADDR_W(20), .IDX_W(4)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iAbort(abort),
        .iPhoto_Index(idx), .iCol_MAX(cmax), .iRow_MAX(rmax), .iSRAM_In(sram_in),
        .oSRAM_Addr(sram_addr), .oSRAM_CE_N(ce_n), .oSRAM_UB_N(ub_n), .oSRAM_LB_N(lb_n),
        .oSRAM_WE_N(we_n), .oSRAM_OE_N(oe_n), .oRGB(rgb), .oValid(valid), .iReady(ready),
        .oSOF(sof), .oEOL(eol), .oEOF(eof), .oBusy(busy), .oDone(done)
    );

    typedef struct {
        logic [29:0] rgb;
        logic [2:0]  mk;
    } beat_t;

    beat_t       expq[$];
    logic [7:0]  log_r[$];
    logic [2:0]  log_m[$];
    bit          busy_m = 0, done_pend = 0;
    bit          prev_valid = 0, prev_ready = 0, prev_abort = 0;
    logic [29:0] prev_rgb = '0;
    int          beats = 0, dones = 0, eof_addr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected beats in raster order, straight from the address formula.
    task automatic build(input int ix, input int c, input int r);
        int base, a;
        beat_t b;
        base = (ix * c * r * 2) % (1 << 20);
        for (int y = 0; y < r; y++) begin
            for (int x = 0; x < c; x++) begin
                a = base + 2 * (y * c + x);
                b.rgb = {sram[a][15:8], 2'b00, sram[a][7:0], 2'b00, sram[a + 1][15:8], 2'b00};
                b.mk  = {(x == 0 && y == 0), (x == c - 1), (x == c - 1 && y == r - 1)};
                expq.push_back(b);
            end
        end
    endtask

    always @(negedge clk) begin
        bit    busy_cur;
        beat_t b;
        if (!rst_n) begin
            chk("rst_addr", 32'(sram_addr), 0);
            chk("rst_rgb", 32'(rgb), 0);
            chk("rst_flags", {valid, sof, eol, eof, busy, done}, 0);
            chk("rst_oe_n", 32'(oe_n), 1);
            expq.delete();
            busy_m = 0; done_pend = 0; prev_valid = 0;
        end else begin
            chk("busy", 32'(busy), 32'(busy_m));
            chk("done", 32'(done), 32'(done_pend));
            chk("oe_n", 32'(oe_n), 32'(!busy_m));
            chk("tied", {ce_n, ub_n, lb_n, we_n}, 4'b0001);
            if (!busy_m) chk("idle_valid", 32'(valid), 0);
            if (prev_valid && !prev_ready && !prev_abort) begin
                chk("hold_valid", 32'(valid), 1);
                chk("hold_rgb", 32'(rgb), 32'(prev_rgb));
            end
            if (done) dones++;
            done_pend = 0;
            busy_cur  = busy_m;
            if (abort) begin
                expq.delete();
                busy_m = 0;
            end else begin
                if (valid && ready) begin
                    if (expq.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL extra_beat: got rgb %0h expected no beat at %0t", rgb, $time);
                    end else begin
                        b = expq.pop_front();
                        chk("rgb", 32'(rgb), 32'(b.rgb));
                        chk("markers", {sof, eol, eof}, 32'(b.mk));
                        beats++;
                        log_r.push_back(rgb[29:22]);
                        log_m.push_back({sof, eol, eof});
                        if (b.mk[0]) begin
                            chk("beats_left", expq.size(), 0);
                            done_pend = 1;
                            busy_m    = 0;
                            eof_addr  = int'(sram_addr);
                        end
                    end
                end
                if (start && !busy_cur) begin
                    if (cmax == 0 || rmax == 0) begin
                        done_pend = 1;
                    end else begin
                        build(idx, cmax, rmax);
                        busy_m = 1;
                    end
                end
            end
            prev_valid = valid; prev_ready = ready; prev_abort = abort; prev_rgb = rgb;
        end
    end

    task automatic pulse_start(input int ix, input int c, input int r);
        @(posedge clk); #1;
        idx = 4'(ix); cmax = 10'(c); rmax = 10'(r); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input string nm);
        for (int k = 0; k < 3000; k++) begin
            if (done) break;
            ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
        end
        chk(nm, 32'(done), 1);
        ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_beat(input int b0, input int n, input string nm);
        for (int k = 0; k < 500; k++) begin
            if (valid && (beats - b0 == n)) break;
            @(posedge clk); #1;
        end
        chk(nm, 32'(valid && (beats - b0 == n)), 1);
    endtask

    initial begin
        int b0, d0, l0, a1;
        logic [29:0] r0;
        logic [2:0]  mk_exp [4];
        mk_exp = '{3'b100, 3'b010, 3'b000, 3'b011};
        for (int i = 0; i < 4096; i++) sram[i] = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            sram[2 * k]     = {8'(k), 8'(k + 16)};
            sram[2 * k + 1] = {8'(k + 32), 8'h00};
        end
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // 2x2 image at slot 0
        ready = 1'b1;
        l0 = log_r.size();
        pulse_start(0, 2, 2);
        chk("t1_addr0", 32'(sram_addr), 0);
        chk("t1_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("t1_valid_early", 32'(valid), 0);
        chk("t1_addr1", 32'(sram_addr), 1);
        @(posedge clk); #1;
        chk("t1_first_valid", 32'(valid), 1);
        chk("t1_first_r", 32'(rgb[29:22]), 0);
        chk("t1_first_b", 32'(rgb[9:2]), 32);
        chk("t1_sof", 32'(sof), 1);
        wait_done(0, "t1_done");
        chk("t1_count", log_r.size() - l0, 4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_r", 32'(log_r[l0 + k]), k);
            chk("t1_mk", 32'(log_m[l0 + k]), 32'(mk_exp[k]));
        end

        // slot 3, 4x3
        b0 = beats; d0 = dones;
        pulse_start(3, 4, 3);
        chk("t2_first_addr", 32'(sram_addr), 72);
        wait_done(0, "t2_done");
        chk("t2_beats", beats - b0, 12);
        chk("t2_last_addr", eof_addr - 1, 95);
        chk("t2_dones", dones - d0, 1);

        // backpressure on pixel 1
        b0 = beats;
        pulse_start(1, 3, 2);
        wait_beat(b0, 1, "t3_reach_px1");
        ready = 1'b0;
        r0 = rgb;
        @(posedge clk); #1;
        a1 = int'(sram_addr);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("t3_valid", 32'(valid), 1);
            chk("t3_rgb", 32'(rgb), 32'(r0));
            chk("t3_addr_held", 32'(sram_addr), a1);
        end
        ready = 1'b1;
        wait_done(0, "t3_done");
        chk("t3_beats", beats - b0, 6);

        // randomized frames with random backpressure
        for (int n = 0; n < 6; n++) begin
            int ix, c, r;
            ix = $urandom_range(0, 15);
            c  = $urandom_range(1, 8);
            r  = $urandom_range(1, 8);
            b0 = beats;
            pulse_start(ix, c, r);
            wait_done(1, "rand_done");
            chk("rand_beats", beats - b0, c * r);
        end

        // abort on pixel 2, then restart
        b0 = beats;
        ready = 1'b1;
        pulse_start(2, 4, 4);
        wait_beat(b0, 2, "t4_reach_px2");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t4_valid", 32'(valid), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_oe_n", 32'(oe_n), 1);
        chk("t4_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        b0 = beats; l0 = log_m.size();
        pulse_start(2, 4, 4);
        wait_done(0, "t4_redo_done");
        chk("t4_redo_beats", beats - b0, 16);
        chk("t4_redo_sof", 32'(log_m[l0]), 32'(3'b100));

        // abort together with start in IDLE
        @(posedge clk); #1;
        idx = 4'd1; cmax = 10'd2; rmax = 10'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("t4b_busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("t4b_busy2", 32'(busy), 0);
        chk("t4b_done", 32'(done), 0);

        // zero dimension, then start during a frame
        pulse_start(5, 0, 3);
        chk("t5_done", 32'(done), 1);
        chk("t5_valid", 32'(valid), 0);
        chk("t5_busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("t5_done_pulse", 32'(done), 0);
        b0 = beats; d0 = dones;
        pulse_start(1, 3, 3);
        repeat (3) @(posedge clk);
        pulse_start(7, 5, 5);
        wait_done(0, "t5_frame_done");
        chk("t5_beats", beats - b0, 9);
        chk("t5_dones", dones - d0, 1);

        // async reset mid-frame
        pulse_start(4, 4, 4);
        repeat (9) @(posedge clk);
        #1;
        chk("t6_busy_before", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_addr", 32'(sram_addr), 0);
        chk("t6_rgb", 32'(rgb), 0);
        chk("t6_flags", {valid, sof, eol, eof, busy, done}, 0);
        chk("t6_oe_n", 32'(oe_n), 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        b0 = beats;
        pulse_start(1, 2, 3);
        wait_done(0, "t6_done");
        chk("t6_beats", beats - b0, 6);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
